// File: rtl/gpu_div_sequencer.sv
// Requester-side sequencer for the pipelined signed divider.
// Credit-limited issue, shadow tag pipeline, in-order FWFT result FIFO.
module gpu_div_sequencer #(
    parameter int OUTSIZE = 20,
    parameter int LATENCY = 6,
    parameter int TAGW    = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_num,
    input  logic [21:0]        i_den,
    input  logic [TAGW-1:0]    i_tag,
    output logic [31:0]        o_divNum,
    output logic [21:0]        o_divDen,
    input  logic [OUTSIZE-1:0] i_divQuot,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [OUTSIZE-1:0] o_quot,
    output logic [TAGW-1:0]    o_tag,
    output logic               o_divZero,
    output logic               o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OUTSIZE-1:0] quot;
        logic [TAGW-1:0]    tag;
        logic               dz;
    } entry_t;

    logic [CW-1:0]      cred_q, cred_d;
    logic [LATENCY-1:0] sv_q;
    logic [LATENCY-1:0] sdz_q;
    logic [LATENCY-1:0] ssg_q;
    logic [TAGW-1:0]    st_q [LATENCY];

    entry_t             mem_q [DEPTH];
    entry_t             push_e;
    entry_t             head;
    logic [AW-1:0]      wp_q, rp_q;
    logic [AW:0]        cnt_q, cnt_d;

    logic accept, pop, push, empty, full, den_zero;

    assign den_zero = (i_den == '0);
    assign o_ready  = (cred_q != '0) & ~reset;
    assign accept   = i_valid & o_ready;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign o_valid  = ~empty;
    assign pop      = o_valid & i_ready;
    assign push     = sv_q[LATENCY-1];

    assign o_divNum = accept ? i_num : 32'd0;
    assign o_divDen = (accept & ~den_zero) ? i_den : 22'd1;

    assign head      = mem_q[rp_q];
    assign o_quot    = head.quot;
    assign o_tag     = head.tag;
    assign o_divZero = o_valid & head.dz;
    assign o_busy    = (|sv_q) | ~empty;

    // Credits: one per FIFO slot, spent on accept, returned on pop.
    always_comb begin
        cred_d = cred_q;
        if (accept & ~pop)
            cred_d = cred_q - CW'(1);
        else if (pop & ~accept)
            cred_d = cred_q + CW'(1);
    end

    // Occupancy follows push/pop, both honoured together.
    always_comb begin
        cnt_d = cnt_q;
        if (push & ~pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop & ~push)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    // Substitute a saturated quotient for jobs that divided by zero.
    always_comb begin
        push_e.tag = st_q[LATENCY-1];
        push_e.dz  = sdz_q[LATENCY-1];
        if (!sdz_q[LATENCY-1])
            push_e.quot = i_divQuot;
        else if (ssg_q[LATENCY-1])
            push_e.quot = {1'b1, {(OUTSIZE-1){1'b0}}};
        else
            push_e.quot = {1'b0, {(OUTSIZE-1){1'b1}}};
    end

    // Credit counter and shadow valids; reset drops all in-flight jobs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cred_q <= CW'(DEPTH);
            sv_q   <= '0;
        end else begin
            cred_q   <= cred_d;
            sv_q[0]  <= accept;
            for (int i = 1; i < LATENCY; i++)
                sv_q[i] <= sv_q[i-1];
        end
    end

    // Shadow job attributes march alongside the divider, never stalling.
    always_ff @(posedge clock) begin
        st_q[0]  <= i_tag;
        sdz_q[0] <= den_zero;
        ssg_q[0] <= i_num[31];
        for (int i = 1; i < LATENCY; i++) begin
            st_q[i]  <= st_q[i-1];
            sdz_q[i] <= sdz_q[i-1];
            ssg_q[i] <= ssg_q[i-1];
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wp_q <= wp_q + AW'(1);
            if (pop)
                rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage; stale contents are hidden by the count.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wp_q] <= push_e;
    end

    assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_gpu_div_sequencer.sv
// Bench for gpu_div_sequencer with a behavioural fixed-latency divider.
// Scoreboard holds expected results in accept order.
module tb_gpu_div_sequencer;
    localparam int OUTSIZE = 20;
    localparam int LATENCY = 6;
    localparam int TAGW    = 4;
    localparam int DEPTH   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_ready = 1'b1;
    logic [31:0]        i_num = '0;
    logic [21:0]        i_den = '0;
    logic [TAGW-1:0]    i_tag = '0;
    logic               o_ready;
    logic [31:0]        o_divNum;
    logic [21:0]        o_divDen;
    logic [OUTSIZE-1:0] i_divQuot;
    logic               o_valid;
    logic [OUTSIZE-1:0] o_quot;
    logic [TAGW-1:0]    o_tag;
    logic               o_divZero;
    logic               o_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct packed {
        logic [OUTSIZE-1:0] q;
        logic [TAGW-1:0]    t;
        logic               dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    gpu_div_sequencer #(
        .OUTSIZE(OUTSIZE), .LATENCY(LATENCY), .TAGW(TAGW), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_num(i_num), .i_den(i_den), .i_tag(i_tag),
        .o_divNum(o_divNum), .o_divDen(o_divDen), .i_divQuot(i_divQuot),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_quot(o_quot), .o_tag(o_tag), .o_divZero(o_divZero),
        .o_busy(o_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Fixed-latency truncating divider model
    logic signed [31:0] dv_n, dv_d, dv_q;
    logic [OUTSIZE-1:0] dpipe [LATENCY];
    assign dv_n = o_divNum;
    assign dv_d = {{10{o_divDen[21]}}, o_divDen};
    assign dv_q = (dv_d == 0) ? 32'sd0 : dv_n / dv_d;
    assign i_divQuot = dpipe[LATENCY-1];
    always @(posedge clock) begin
        dpipe[0] <= dv_q[OUTSIZE-1:0];
        for (int i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
    end

    function automatic logic [OUTSIZE-1:0] exp_q(input logic signed [31:0] n,
                                                 input logic signed [21:0] d);
        logic signed [31:0] dd, q;
        if (d == 0) return n[31] ? 20'h80000 : 20'h7FFFF;
        dd = d;
        q = n / dd;
        return q[OUTSIZE-1:0];
    endfunction

    // Operand checks every cycle, scoreboard push on accept, pop on result
    always @(negedge clock) begin
        if (i_valid && o_ready) begin
            checks++;
            if (o_divNum !== i_num || o_divDen !== ((i_den == 0) ? 22'd1 : i_den))
                $display("FAIL accept_operands num=%h den=%h want num=%h den=%h",
                         o_divNum, o_divDen, i_num, (i_den == 0) ? 22'd1 : i_den);
            if (o_divNum !== i_num || o_divDen !== ((i_den == 0) ? 22'd1 : i_den))
                errors++;
            mon_e.q  = exp_q(i_num, i_den);
            mon_e.t  = i_tag;
            mon_e.dz = (i_den == 0);
            sb.push_back(mon_e);
        end else begin
            checks++;
            if (o_divNum !== 32'd0 || o_divDen !== 22'd1) begin
                errors++;
                $display("FAIL idle_operands num=%h den=%h want 0/1", o_divNum, o_divDen);
            end
        end
        if (!reset && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result quot=%h tag=%h", o_quot, o_tag);
            end else begin
                mon_e = sb.pop_front();
                if ({o_quot, o_tag, o_divZero} !== mon_e) begin
                    errors++;
                    $display("FAIL result quot=%h tag=%h dz=%b want quot=%h tag=%h dz=%b",
                             o_quot, o_tag, o_divZero, mon_e.q, mon_e.t, mon_e.dz);
                end
            end
        end
    end

    task automatic send(input int n, input int d, input int t, output int ac);
        @(posedge clock); #1;
        i_valid = 1'b1;
        i_num = n;
        i_den = 22'(d);
        i_tag = 4'(t);
        ac = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (o_ready) begin
                ac = cyc;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        i_valid = 1'b0;
        checks++;
        if (ac < 0) begin
            errors++;
            $display("FAIL send_timeout tag=%0d got no accept want accept", t);
        end
    endtask

    task automatic wait_valid(output int vc);
        vc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (o_valid) begin
                vc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || o_busy) && k < 100) begin
            @(negedge clock); #1;
            k++;
        end
        checks++;
        if (sb.size() != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain pending=%0d busy=%b want 0/0", sb.size(), o_busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        @(negedge clock);
        checks++;
        if ({o_ready, o_valid, o_busy, o_divZero} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags rdy/vld/busy/dz=%b want 0000",
                     {o_ready, o_valid, o_busy, o_divZero});
        end
        checks++;
        if (o_divNum !== 32'd0 || o_divDen !== 22'd1) begin
            errors++;
            $display("FAIL reset_operands num=%h den=%h want 0/1", o_divNum, o_divDen);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b want 1", o_ready);
        end
    endtask

    task automatic test_single();
        int ac, vc;
        send(100, 7, 3, ac);
        wait_valid(vc);
        checks++;
        if (vc - ac != LATENCY + 1) begin
            errors++;
            $display("FAIL single_latency got=%0d want=%0d", vc - ac, LATENCY + 1);
        end
        checks++;
        if ({o_quot, o_tag, o_divZero} !== {20'd14, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL single_data quot=%h tag=%h dz=%b want 0000e/3/0",
                     o_quot, o_tag, o_divZero);
        end
        @(negedge clock);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b valid=%b want 0/0", o_busy, o_valid);
        end
    endtask

    task automatic test_signed();
        int n[3] = '{-100, 100, -100};
        int d[3] = '{7, -7, -7};
        logic [OUTSIZE-1:0] q[3] = '{20'hFFFF2, 20'hFFFF2, 20'd14};
        int ac, vc;
        for (int i = 0; i < 3; i++) begin
            send(n[i], d[i], 5 + i, ac);
            wait_valid(vc);
            checks++;
            if (o_quot !== q[i] || o_divZero !== 1'b0) begin
                errors++;
                $display("FAIL signed_%0d quot=%h dz=%b want %h/0",
                         i, o_quot, o_divZero, q[i]);
            end
        end
        wait_drain();
    endtask

    task automatic test_divzero();
        int n[2] = '{5, -1000};
        logic [OUTSIZE-1:0] q[2] = '{20'h7FFFF, 20'h80000};
        int ac, vc;
        for (int i = 0; i < 2; i++) begin
            send(n[i], 0, 10 + i, ac);
            wait_valid(vc);
            checks++;
            if (o_quot !== q[i] || o_divZero !== 1'b1) begin
                errors++;
                $display("FAIL divzero_%0d quot=%h dz=%b want %h/1",
                         i, o_quot, o_divZero, q[i]);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int j = 0, acc = 0, a8 = -1, low = -1, p = -1, rise = -1;
        logic took;
        @(posedge clock); #1;
        i_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i_valid = (j < 10);
            i_num = 1000 + j * 37;
            i_den = 22'(j + 1);
            i_tag = 4'(j);
            @(negedge clock);
            took = i_valid && o_ready;
            if (took) begin
                acc++;
                if (acc == DEPTH) a8 = cyc;
            end else if (!o_ready && low < 0) begin
                low = cyc;
            end
            @(posedge clock); #1;
            if (took) j++;
        end
        checks++;
        if (acc != DEPTH) begin
            errors++;
            $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH);
        end
        checks++;
        if (low != a8 + 1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_fall got=%0d ready=%b want=%0d/0", low, o_ready, a8 + 1);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            i_valid = (j < 10);
            i_num = 1000 + j * 37;
            i_den = 22'(j + 1);
            i_tag = 4'(j);
            @(negedge clock);
            if (o_valid && p < 0) p = cyc;
            if (o_ready && rise < 0) rise = cyc;
            took = i_valid && o_ready;
            @(posedge clock); #1;
            if (took) j++;
        end
        i_valid = 1'b0;
        checks++;
        if (p < 0 || rise != p + 1) begin
            errors++;
            $display("FAIL bp_ready_rise got=%0d want=%0d", rise, p + 1);
        end
        checks++;
        if (j != 10) begin
            errors++;
            $display("FAIL bp_total got=%0d want=10", j);
        end
        wait_drain();
    endtask

    task automatic test_streaming();
        int j = 0, cycles = 0, pops = 0, first = -1, last = -1, sg;
        logic took;
        @(posedge clock); #1;
        i_ready = 1'b1;
        while (j < 32 && cycles < 64) begin
            i_valid = 1'b1;
            i_num = int'($urandom_range(0, 200000)) - 100000;
            sg = ($urandom_range(0, 1) == 1) ? -1 : 1;
            i_den = (j % 7 == 3) ? 22'd0 : 22'(sg * int'($urandom_range(1, 2000)));
            i_tag = 4'(j);
            @(negedge clock);
            took = o_ready;
            if (o_valid) begin
                pops++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clock); #1;
            if (took) j++;
            cycles++;
        end
        i_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (o_valid) begin
                pops++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++;
        if (cycles != 32) begin
            errors++;
            $display("FAIL stream_accept_cycles got=%0d want=32", cycles);
        end
        checks++;
        if (pops != 32 || last - first != 31) begin
            errors++;
            $display("FAIL stream_pops got=%0d span=%0d want=32/31", pops, last - first);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int ac, vc, seen = 0;
        @(posedge clock); #1;
        for (int t = 0; t < 3; t++) begin
            i_valid = 1'b1;
            i_num = 50 + t;
            i_den = 22'd5;
            i_tag = 4'(t + 9);
            @(posedge clock); #1;
        end
        i_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state rdy=%b vld=%b busy=%b want 1/0/0",
                     o_ready, o_valid, o_busy);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (o_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_leak got=%0d results want=0", seen);
        end
        send(9, 3, 2, ac);
        wait_valid(vc);
        checks++;
        if (vc - ac != LATENCY + 1 || o_quot !== 20'd3 || o_tag !== 4'd2) begin
            errors++;
            $display("FAIL mid_reset_job lat=%0d quot=%h tag=%h want %0d/3/2",
                     vc - ac, o_quot, o_tag, LATENCY + 1);
        end
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_divzero();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
